// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: key conditioner FSM state encoding.
package stopwatch_pkg;

    // Two-bit encoding; every code is a named state, and the FSM still
    // sends anything unexpected back to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } key_state_t;

endpackage

// File: rtl/key_debouncer_if.sv
// Key conditioner signal bundle: raw pin in, debounced level and event pulses out.
// The event outputs are plain strobes with no handshake. Each pulse is high for
// exactly one clk cycle, and the consumer must sample it on that edge.
// The state field is a read-only debug view of the conditioner FSM.
interface key_debouncer_if;
    import stopwatch_pkg::*;

    logic       key_raw;
    logic       key_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    key_state_t state;

    // Board/test side drives the pin and observes the events.
    modport master (
        output key_raw,
        input  key_level, press_pulse, release_pulse, long_pulse, state
    );

    // Conditioner side.
    modport slave (
        input  key_raw,
        output key_level, press_pulse, release_pulse, long_pulse, state
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-stage flip-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Both stages load RESET_VALUE so no false edge appears after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debouncer.sv
// Push-button conditioner: polarity normalise, synchronise, debounce, and emit
// single-cycle press / release / long-press pulses.
module key_debouncer
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 1000,
    parameter int unsigned LONG_PRESS_CYCLES = 50000,
    parameter bit          KEY_ACTIVE_LOW    = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    key_debouncer_if.slave kif
);

    localparam int CW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(LONG_PRESS_CYCLES - 1);

    logic          key_n;
    logic          key_s;
    key_state_t    state;
    logic [CW-1:0] cnt;        // stability count for the pending level change
    logic [CW-1:0] hold_cnt;   // cycles since press acceptance, saturating
    logic          long_done;  // long_pulse already issued for this hold
    logic          key_level;
    logic          press_pulse;
    logic          release_pulse;
    logic          long_pulse;

    // 1 = pressed from here on, whatever the pin polarity.
    assign key_n = KEY_ACTIVE_LOW ? ~kif.key_raw : kif.key_raw;

    sync_2ff #(.RESET_VALUE(1'b0)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (key_n),
        .q     (key_s)
    );

    // Debounce FSM with registered level and pulses. The hold counter keeps
    // running through a release candidate, so a short glitch during a hold
    // neither restarts the long-press timer nor re-arms long_pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            hold_cnt      <= '0;
            long_done     <= 1'b0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;

            if ((state == ST_PRESSED || state == ST_RELEASE_WAIT) && hold_cnt != HOLD_LAST)
                hold_cnt <= hold_cnt + CW'(1);

            case (state)
                ST_IDLE: begin
                    if (key_s) begin
                        state <= ST_PRESS_WAIT;
                        cnt   <= CW'(1);
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!key_s) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state       <= ST_PRESSED;
                        key_level   <= 1'b1;
                        press_pulse <= 1'b1;
                        cnt         <= '0;
                        hold_cnt    <= '0;
                        long_done   <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_PRESSED: begin
                    if (!key_s) begin
                        state <= ST_RELEASE_WAIT;
                        cnt   <= CW'(1);
                    end else if (!long_done && hold_cnt == HOLD_LAST) begin
                        long_pulse <= 1'b1;
                        long_done  <= 1'b1;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (key_s) begin
                        state <= ST_PRESSED;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state         <= ST_IDLE;
                        key_level     <= 1'b0;
                        release_pulse <= 1'b1;
                        long_done     <= 1'b0;
                        cnt           <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    key_level <= 1'b0;
                    long_done <= 1'b0;
                end
            endcase
        end
    end

    assign kif.key_level     = key_level;
    assign kif.press_pulse   = press_pulse;
    assign kif.release_pulse = release_pulse;
    assign kif.long_pulse    = long_pulse;
    assign kif.state         = state;

endmodule
